// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM state type and read-latency constants for sram_seq_ctrl.
package sram_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, OUTPUT, DONE} state_t;
  localparam int RD_LATENCY = 2;
  localparam int LAT_W = $clog2(RD_LATENCY + 1);
endpackage

// File: rtl/sram_seq_ctrl_fib_gen.sv
// fib_gen: Fibonacci sequence registers and adder; SRAM_SEQ_SAT_EN makes the addition saturate.
module fib_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] value
);
  logic [DATA_WIDTH-1:0] a_q, b_q, b_d;
`ifdef SRAM_SEQ_SAT_EN
  logic [DATA_WIDTH:0] sum;
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign b_d = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
`else
  assign b_d = a_q + b_q;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst || clear) begin
      a_q <= '0;
      b_q <= DATA_WIDTH'(1);
    end else if (step) begin
      a_q <= b_q;
      b_q <= b_d;
    end
  assign value = a_q;
endmodule

// File: rtl/sram_seq_ctrl.sv
// sram_seq_ctrl: fills an SRAM with a Fibonacci table, then streams it back with backpressure.
// Optional macro SRAM_SEQ_SAT_EN selects saturating (instead of wrapping) fib addition.
module sram_seq_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LAT_W-1:0]      lat_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  busy_q, done_q, we_q, oe_q, valid_q, last_q;
  logic                  fib_clear, fib_step;
  assign fib_clear = (state_q == IDLE) && start;
  assign fib_step  = (state_q == WRITE);
  fib_gen #(.DATA_WIDTH(DATA_WIDTH)) u_fib (
    .clk  (clk),
    .rst  (rst),
    .clear(fib_clear),
    .step (fib_step),
    .value(mem_wdata)
  );
  // Output flags are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      lat_q      <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= WRITE;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
          end
        WRITE:
          if (&addr_q) begin
            state_q <= READ;
            addr_q  <= '0;
            lat_q   <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b1;
          end else
            addr_q <= addr_q + ADDR_WIDTH'(1);
        READ:
          if (lat_q == LAT_W'(RD_LATENCY)) begin
            state_q    <= OUTPUT;
            out_data_q <= mem_rdata;
            oe_q       <= 1'b0;
            valid_q    <= 1'b1;
            last_q     <= &addr_q;
          end else
            lat_q <= lat_q + LAT_W'(1);
        OUTPUT:
          if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              addr_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              addr_q  <= addr_q + ADDR_WIDTH'(1);
              lat_q   <= '0;
              oe_q    <= 1'b1;
            end
          end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;
  assign mem_addr  = addr_q;
  assign out_valid = valid_q;
  assign out_data  = out_data_q;
  assign out_last  = last_q;
endmodule

// File: doc/sram_seq_ctrl.md
SRAM_SEQ_CTRL -- requirements
Module: sram_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: SRAM address width; depth = 2^ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: SRAM word and stream width.
REQ-003 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1: one-cycle request to begin a run; sampled only in IDLE.
REQ-006 SHALL have port busy  out  1: high in every state except IDLE.
REQ-007 SHALL have port done  out  1: one-cycle pulse at end of run.
REQ-008 SHALL have port mem_we  out  1: SRAM write enable, active high.
REQ-009 SHALL have port mem_oe  out  1: SRAM output enable, active high.
REQ-010 SHALL have port mem_addr  out  ADDR_WIDTH: SRAM address.
REQ-011 SHALL have port mem_wdata  out  DATA_WIDTH: SRAM write data.
REQ-012 SHALL have port mem_rdata  in  DATA_WIDTH: SRAM read data, registered output of the SRAM wrapper.
REQ-013 SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_WIDTH, out_last out 1: read-back stream.

Function
REQ-014 SHALL implement states IDLE, WRITE, READ, OUTPUT, DONE.
REQ-015 IDLE->WRITE on start; start in any other state SHALL be ignored.
REQ-016 WRITE: one entry per cycle, addr 0..2^ADDR_WIDTH-1, mem_we=1, mem_wdata=F(addr), F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2) truncated to DATA_WIDTH (wraps).
REQ-017 After last address written, SHALL go to READ with read address 0.
REQ-018 READ: mem_oe=1, mem_we=0, mem_addr held for RD_LATENCY+1 cycles (RD_LATENCY=2); mem_rdata captured into out_data at the closing edge of the last READ cycle; then OUTPUT.
REQ-019 OUTPUT: out_valid=1; out_data, out_last stable until out_valid&&out_ready; mem_oe=0.
REQ-020 On handshake, SHALL increment read address and return to READ, or go to DONE if out_last.
REQ-021 out_last SHALL be high only while outputting address 2^ADDR_WIDTH-1.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 mem_we and mem_oe SHALL never be high in the same cycle.
REQ-024 Address counters SHALL wrap only via state change, never overrun to 0 within a phase.

Reset
REQ-025 rst SHALL immediately force IDLE, counters 0, fib registers (F(n-2),F(n-1)) to (0,1).
REQ-026 Reset values: busy, done, mem_we, mem_oe, out_valid, out_last = 0; mem_addr, mem_wdata, out_data = 0.
REQ-027 rst mid-run SHALL abort; no further SRAM write occurs until a new start.

Configuration
REQ-028 Macro SRAM_SEQ_SAT_EN defined: fib addition SHALL saturate at 2^DATA_WIDTH-1.
REQ-029 Macro undefined: addition SHALL wrap modulo 2^DATA_WIDTH.

Structure
REQ-030 Package sram_ctrl_pkg SHALL hold the state enum typedef and constant RD_LATENCY=2.
REQ-031 Sub-module fib_gen (clear, step, value out; honours SRAM_SEQ_SAT_EN) SHALL hold the sequence registers and adder.

Verification
REQ-032 Reset: rst=1 with random inputs -> all outputs 0, busy=0.
REQ-033 Full run, out_ready=1, wrap build: stream = 0,1,1,2,3,5,8,13,21,34,55,89,144,233,121,98; out_last only on 98; done one cycle later.
REQ-034 SRAM_SEQ_SAT_EN build, same run: entries 14,15 = 255,255; others as REQ-033.
REQ-035 Backpressure: out_ready low 5 cycles on entry 3 -> out_data=2 held, out_valid=1, no address advance.
REQ-036 start pulsed during WRITE and READ -> ignored; exactly 16 writes, 16 beats.
REQ-037 rst asserted at write address 7 -> mem_we drops immediately, IDLE; new start rewrites from address 0.
